// File: rtl/alu_op_seq.sv
// ==========================================================================
// alu_op_seq : Moore sequencer driving register-file reads/writes and ALU
//              operand loads for one unary/reg-reg/reg-imm op.  rev 1.0
// ==========================================================================
`default_nettype none

module alu_op_seq #(
  parameter int NREG     = 4,
  parameter int IDXW     = 6,
  parameter int WAIT_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic [IDXW-1:0] src1_idx,
  input  logic [IDXW-1:0] src2_idx,
  input  logic            alu_rdy,
  output logic [NREG-1:0] rd_en,
  output logic [NREG-1:0] wr_en,
  output logic [2:0]      alu_io,
  output logic            imm_sel,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int              WCW       = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [31:0]     NREG_U    = 32'(NREG);

  localparam logic [1:0] MODE_UN  = 2'b00;
  localparam logic [1:0] MODE_RR  = 2'b01;
  localparam logic [1:0] MODE_RES = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RDA  = 4'd1,
    S_LDA  = 4'd2,
    S_RDB  = 4'd3,
    S_LDB  = 4'd4,
    S_EXE  = 4'd5,
    S_WB   = 4'd6,
    S_DONE = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [IDXW-1:0] src1_q, src1_d;
  logic [IDXW-1:0] src2_q, src2_d;
  logic [WCW-1:0]  wait_q, wait_d;

  logic            src1_bad, src2_bad;
  logic [NREG-1:0] oh1, oh2;

  assign src1_bad = (32'(src1_idx) >= NREG_U);
  assign src2_bad = (32'(src2_idx) >= NREG_U);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    // Counter sits at zero outside EXE, so it is cleared on every EXE entry.
    wait_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          src1_d = src1_idx;
          src2_d = src2_idx;
          if (mode == MODE_RES || src1_bad || (mode == MODE_RR && src2_bad))
            state_d = S_ERR;
          else
            state_d = S_RDA;
        end
      end
      S_RDA:  state_d = S_LDA;
      S_LDA:  state_d = (mode_q == MODE_UN) ? S_EXE : S_RDB;
      S_RDB:  state_d = S_LDB;
      S_LDB:  state_d = S_EXE;
      S_EXE: begin
        if (alu_rdy)
          state_d = S_WB;
        else if (wait_q == WAIT_LAST)
          state_d = S_ERR;
        else
          wait_d = wait_q + WCW'(1);
      end
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      wait_d  = '0;
    end
  end

  always_comb begin
    oh1 = '0;
    oh2 = '0;
    for (int i = 0; i < NREG; i++) begin
      oh1[i] = (32'(src1_q) == 32'(i));
      oh2[i] = (32'(src2_q) == 32'(i));
    end
  end

  always_comb begin
    rd_en   = '0;
    wr_en   = '0;
    alu_io  = 3'b000;
    imm_sel = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_RDA: rd_en = oh1;
      S_LDA: begin
        rd_en  = oh1;
        alu_io = 3'b100;
      end
      S_RDB, S_LDB: begin
        if (mode_q == MODE_RR) rd_en = oh2;
        else                   imm_sel = 1'b1;
        if (state_q == S_LDB)  alu_io = 3'b010;
      end
      S_WB: begin
        wr_en  = oh1;
        alu_io = 3'b001;
      end
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/alu_op_seq.md
ALU_OP_SEQ -- requirements
Module: alu_op_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NREG SHALL default to 4 and set the number of registers, one enable bit each.
REQ-003 Parameter IDXW SHALL default to 6 and set the register-index width.
REQ-004 Parameter WAIT_MAX SHALL default to 8 and set the maximum EXE cycles allowed without alu_rdy; it SHALL be at least 1.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  launches one operation when sampled high in IDLE.
REQ-008 abort  in  1  cancels any operation in progress.
REQ-009 mode  in  2  00 unary, 01 register-register, 10 register-immediate, 11 reserved.
REQ-010 src1_idx  in  IDXW  operand A register index; also the destination register index.
REQ-011 src2_idx  in  IDXW  operand B register index; used in mode 01 only.
REQ-012 alu_rdy  in  1  the ALU result is valid.
REQ-013 rd_en  out  NREG  one-hot register read enable.
REQ-014 wr_en  out  NREG  one-hot register write enable.
REQ-015 alu_io  out  3  100 load A, 010 load B, 001 drive result, 000 idle.
REQ-016 imm_sel  out  1  operand B is taken from the immediate path.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  one-cycle error pulse.

Function
REQ-020 States SHALL be IDLE, RDA, LDA, RDB, LDB, EXE, WB, DONE and ERR; all outputs SHALL be decoded from the state register only (Moore).
REQ-021 When start is sampled high in IDLE, mode, src1_idx and src2_idx SHALL be latched; later changes to these inputs SHALL have no effect until the next start.
REQ-022 In IDLE, start SHALL cause a transition to ERR if mode is 11, if src1_idx >= NREG, or if mode is 01 and src2_idx >= NREG; otherwise the transition SHALL be to RDA.
REQ-023 In RDA, rd_en[src1] SHALL be 1; the next state SHALL be LDA.
REQ-024 In LDA, rd_en[src1] SHALL be 1 and alu_io SHALL be 100; the next state SHALL be EXE for mode 00 and RDB otherwise.
REQ-025 In RDB, rd_en[src2] SHALL be 1 in mode 01, or imm_sel SHALL be 1 with rd_en all zero in mode 10; the next state SHALL be LDB.
REQ-026 In LDB, the RDB enables SHALL be held and alu_io SHALL be 010; the next state SHALL be EXE.
REQ-027 In EXE, all enables SHALL be 0 and alu_io SHALL be 000.
REQ-028 In EXE, alu_rdy high SHALL cause a transition to WB.
REQ-029 In EXE, a wait counter SHALL be cleared on entry and increment each EXE cycle; if alu_rdy is still low in the WAIT_MAX-th EXE cycle, the next state SHALL be ERR.
REQ-030 In WB, alu_io SHALL be 001 and wr_en[src1] SHALL be 1; the next state SHALL be DONE.
REQ-031 In DONE, done SHALL be 1; the next state SHALL be IDLE.
REQ-032 In ERR, err SHALL be 1; the next state SHALL be IDLE.
REQ-033 In ERR, rd_en and wr_en SHALL be zero.
REQ-034 At most one bit of rd_en and at most one bit of wr_en SHALL be high in any cycle, and rd_en and wr_en SHALL never both be nonzero.
REQ-035 Latency with alu_rdy held high SHALL be: done asserted 5 cycles after the start sample edge in mode 00, and 7 cycles after in modes 01 and 10.
REQ-036 A start sampled while busy is high SHALL be ignored.
REQ-037 A start sampled in the same cycle as DONE or ERR SHALL be ignored.
REQ-038 abort high in any non-IDLE state SHALL force IDLE on the next edge, with no done or err pulse.
REQ-039 abort SHALL take precedence over start and alu_rdy; abort in IDLE SHALL have no effect.

Reset
REQ-040 rst high SHALL force IDLE on the next edge, clear the latched fields and the wait counter, and drive rd_en=0, wr_en=0, alu_io=000, imm_sel=0, busy=0, done=0 and err=0.
REQ-041 rst SHALL take priority over abort and start, including when asserted mid-operation.

Verification
REQ-042 Unary: NREG=4, mode=00, src1=2, alu_rdy=1 -> rd_en=0100 for 2 cycles with alu_io=100 on the second; EXE 1 cycle; wr_en=0100 with alu_io=001; done at cycle 5.
REQ-043 Binary: mode=01, src1=0, src2=3 -> rd_en 0001,0001,1000,1000; alu_io 100 then 010; wr_en=0001; done at cycle 7.
REQ-044 Immediate with stall: mode=10, src1=1, alu_rdy rising in the 3rd EXE cycle -> imm_sel=1 for 2 cycles, EXE lasts 3 cycles, wr_en=0010, done at cycle 9.
REQ-045 Errors: src1=4 with NREG=4, or mode=11, or alu_rdy held low -> err one cycle (after WAIT_MAX=8 EXE cycles in the timeout case), no wr_en, then IDLE.
REQ-046 Abort/reset: abort in LDB, and separately rst in WB -> IDLE next cycle, all outputs zero, no done; a start during busy is ignored.
